// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream registered-read FIFO.
// Frame: start, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StStart, StData, StParity, StStop
  } state_e;

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        bit_end;

  assign bit_end = (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    frame_count_d = frame_count_q;
    fifo_rd_en    = 1'b0;
    tx            = 1'b1;
    tx_done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        fifo_rd_en = 1'b1;
        state_d    = StLatch;
      end
      StLatch: begin
        // Registered FIFO output is valid exactly one cycle after the strobe.
        shift_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_idx_d = '0;
        state_d   = StStart;
      end
      StStart: begin
        tx = 1'b0;
        if (bit_end) state_d = StData;
        else         cnt_d   = cnt_q + 16'd1;
      end
      StData: begin
        tx = shift_q[bit_idx_q];
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = PARITY_EN ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StParity: begin
        tx = parity_q;
        if (bit_end) state_d = StStop;
        else         cnt_d   = cnt_q + 16'd1;
      end
      StStop: begin
        if (bit_end) begin
          tx_done       = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign frame_count = frame_count_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts one even-parity bit after the data bits.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port fifo_empty  input  1: empty flag from the upstream 8-bit FIFO.
REQ-006 Port fifo_data  input  8: FIFO read data, registered in the FIFO, valid the cycle after a read strobe.
REQ-007 Port fifo_rd_en  output  1: read strobe to the FIFO.
REQ-008 Port tx  output  1: UART serial line, idle high.
REQ-009 Port busy  output  1: high whenever the state is not IDLE.
REQ-010 Port tx_done  output  1: one-cycle pulse at the end of each frame's stop bit.
REQ-011 Port frame_count  output  16: count of completed frames.

Function
REQ-012 States SHALL be IDLE, FETCH, LATCH, START, DATA, PARITY, STOP.
REQ-013 IDLE -> FETCH when fifo_empty=0; otherwise remain in IDLE with tx=1.
REQ-014 FETCH SHALL last exactly 1 cycle and assert fifo_rd_en=1; fifo_rd_en SHALL be 0 in every other state.
REQ-015 LATCH SHALL last 1 cycle, load fifo_data into the 8-bit shift register, and compute parity as the XOR of those 8 bits.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA: 8 bits, LSB first, each held on tx for CLKS_PER_BIT cycles; bit index 0..7; after bit 7 go to PARITY if PARITY_EN=1, else to STOP.
REQ-018 PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; on the last cycle, tx_done=1 and frame_count increments; next state is IDLE.
REQ-020 Latency: the first START cycle SHALL occur 3 cycles after the IDLE cycle that sees fifo_empty=0 (IDLE, FETCH, LATCH, START).
REQ-021 Back-to-back operation: the cycle after STOP is IDLE; if fifo_empty=0 there, FETCH follows. The inter-frame gap is therefore 3 cycles of tx=1 beyond the stop bit.
REQ-022 The baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, and clear on every state or bit change.
REQ-023 frame_count SHALL wrap from 0xFFFF to 0x0000.
REQ-024 fifo_empty and fifo_data SHALL be ignored outside IDLE and LATCH, respectively; the shift register SHALL be stable for the whole frame.
REQ-025 Each frame SHALL issue exactly one fifo_rd_en pulse; no read SHALL be issued while fifo_empty=1 in IDLE.

Reset
REQ-026 When rst=1, the block SHALL asynchronously enter IDLE with tx=1, fifo_rd_en=0, busy=0, tx_done=0, frame_count=0, and the shift register, parity, bit index, and baud counter all cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame; tx SHALL return high immediately, and the partially sent byte SHALL NOT be retransmitted.
REQ-028 After rst deasserts, the first FETCH SHALL occur no earlier than the first rising edge at which fifo_empty=0 is seen in IDLE.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Idle: rst pulse with fifo_empty=1 for 100 cycles -> tx=1, fifo_rd_en=0, busy=0, frame_count=0 throughout.
REQ-030 Single byte 0xA5, PARITY_EN=0 -> one rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; tx_done pulses once; frame_count=1.
REQ-031 PARITY_EN=1, bytes 0x03 then 0x07 -> parity bits 0 and 1 respectively; each frame is 44 cycles of line time.
REQ-032 Three queued bytes 0x11, 0x22, 0x33 -> three frames in order; each consecutive stop-bit end to START gap is exactly 3 cycles; frame_count=3.
REQ-033 rst asserted on the 3rd DATA bit of byte 0x5A -> tx=1 in the same cycle, busy=0, frame_count=0; after release with the FIFO holding 0x3C, the next frame carries 0x3C.
REQ-034 frame_count preloaded near wrap (by forcing or by 65536 frames with CLKS_PER_BIT=2) -> value goes 0xFFFF -> 0x0000 on the next tx_done.
